uart_tx_framer: RTL

UART transmit framer: serialises bytes onto TxD as start / data (LSB first) / optional parity / stop frames.
Clocked by the same 16x-baud Clock as the UART receive path; each bit lasts OVERSAMPLE Clock cycles, so no separate baud enable is needed.
A one-entry holding register with a valid/ready handshake allows back-to-back frames with no idle gap.
Sits between the memory-mapped IO write port and the TxD pin.

---
 rtl/uart_tx_framer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start / data (LSB first) / optional parity / stop frames,
// with one bit every OVERSAMPLE clocks and a one-entry holding register.
module uart_tx_framer #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [DATA_BITS-1:0] TxData,
   input  logic                 TxValid,
   output logic                 TxReady,
   output logic                 TxD,
   output logic                 Busy,
   output logic                 TxDone
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CYC_LAST  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          PAR_INV   = (PARITY == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cyc, cyc_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 par, par_n;
   logic                 txd_n;
   logic                 hold_full;
   logic [DATA_BITS-1:0] hold_data;
   logic                 load;
   logic                 last_cyc;
   logic                 last_stop;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         cyc     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par     <= 1'b0;
         TxD     <= 1'b1;
      end else begin
         state   <= state_n;
         cyc     <= cyc_n;
         bit_cnt <= bit_n;
         shift   <= shift_n;
         par     <= par_n;
         TxD     <= txd_n;
      end
   end

   // Accept and load never coincide: accept needs the register empty, load needs it full.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (load) begin
         hold_full <= 1'b0;
      end else if (TxValid && TxReady) begin
         hold_full <= 1'b1;
         hold_data <= TxData;
      end
   end

   always_comb begin
      last_cyc  = (cyc == CYC_LAST);
      last_stop = (state == STOP) && last_cyc && (bit_cnt == STOP_LAST);
   end

   always_comb begin
      state_n = state;
      cyc_n   = cyc;
      bit_n   = bit_cnt;
      shift_n = shift;
      par_n   = par;
      txd_n   = TxD;
      load    = 1'b0;
      if (state != IDLE) begin
         cyc_n = last_cyc ? '0 : cyc + 1'b1;
      end
      case (state)
         IDLE: begin
            txd_n = 1'b1;
            load  = hold_full;
         end
         START: begin
            if (last_cyc) begin
               state_n = DATA;
               txd_n   = shift[0];
            end
         end
         DATA: begin
            if (last_cyc) begin
               par_n   = par ^ shift[0];
               shift_n = shift >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_n = '0;
                  if (PARITY != 0) begin
                     state_n = PAR;
                     txd_n   = par ^ shift[0] ^ PAR_INV;
                  end else begin
                     state_n = STOP;
                     txd_n   = 1'b1;
                  end
               end else begin
                  bit_n = bit_cnt + 1'b1;
                  txd_n = shift[1];
               end
            end
         end
         PAR: begin
            if (last_cyc) begin
               state_n = STOP;
               txd_n   = 1'b1;
            end
         end
         STOP: begin
            if (last_cyc) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_n   = '0;
                  state_n = IDLE;
                  txd_n   = 1'b1;
                  load    = hold_full;
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            txd_n   = 1'b1;
         end
      endcase
      // Loading from IDLE or from the final stop cycle both begin a start bit at once.
      if (load) begin
         state_n = START;
         shift_n = hold_data;
         par_n   = 1'b0;
         bit_n   = '0;
         cyc_n   = '0;
         txd_n   = 1'b0;
      end
   end

   always_comb begin
      TxReady = ~hold_full;
      Busy    = (state != IDLE);
      TxDone  = last_stop;
   end

endmodule
